// File: rtl/bresenham_line_engine.sv
// bresenham_line_engine: all-octant Bresenham rasteriser streaming one pixel per cycle over valid/ready
module bresenham_line_engine #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] color,
  input  logic               abort,
  output logic               busy,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic [COLOR_W-1:0] px_color,
  output logic               px_last,
  output logic               done
);
  localparam int EW = COORD_W + 2;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  state_t state, state_nx;
  logic [COORD_W-1:0] xa, ya, xb, yb, x, y;
  logic [COLOR_W-1:0] col;
  logic signed [EW-1:0] dx, dy, err, adx, ady;
  logic signed [EW:0] e2;
  logic sx, sy, step_x, step_y, fire;

  assign adx      = EW'((xa < xb) ? xb - xa : xa - xb);
  assign ady      = EW'((ya < yb) ? yb - ya : ya - yb);
  assign e2       = {err, 1'b0};
  assign step_x   = e2 >= dy;
  assign step_y   = e2 <= dx;
  assign px_valid = state == DRAW;
  assign px_last  = px_valid && x == xb && y == yb;
  assign fire     = px_valid && px_ready;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign px_x     = x;
  assign px_y     = y;
  assign px_color = col;

  // state register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;

  // next-state: abort wins in SETUP/DRAW, DONE always lasts one cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SETUP : IDLE;
      SETUP:   state_nx = abort ? IDLE : DRAW;
      DRAW:    state_nx = abort ? IDLE : (fire && px_last) ? DONE : DRAW;
      default: state_nx = IDLE;
    endcase
  end

  // command latch, setup of deltas/directions, and one Bresenham step per accepted pixel
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      xa  <= '0;
      ya  <= '0;
      xb  <= '0;
      yb  <= '0;
      col <= '0;
      x   <= '0;
      y   <= '0;
      dx  <= '0;
      dy  <= '0;
      err <= '0;
      sx  <= 1'b0;
      sy  <= 1'b0;
    end else if (state == IDLE && start) begin
      xa  <= x0;
      ya  <= y0;
      xb  <= x1;
      yb  <= y1;
      col <= color;
    end else if (state == SETUP) begin
      dx  <= adx;
      dy  <= -ady;
      err <= adx - ady;
      sx  <= xa < xb;
      sy  <= ya < yb;
      x   <= xa;
      y   <= ya;
    end else if (fire && !px_last) begin
      err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
      x   <= step_x ? (sx ? x + 1'b1 : x - 1'b1) : x;
      y   <= step_y ? (sy ? y + 1'b1 : y - 1'b1) : y;
    end
endmodule

// File: tb/tb_bresenham_line_engine.sv
// tb_bresenham_line_engine: vector table + scoreboard bench for the line rasteriser
module tb_bresenham_line_engine;
  localparam int CW = 8;
  localparam int KW = 8;

  logic clk = 0, n_rst = 0, start = 0, abort = 0, px_ready = 0;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, px_x, px_y;
  logic [KW-1:0] color = '0, px_color;
  logic busy, px_valid, px_last, done;

  int vectors = 0, miscompares = 0;

  typedef struct {int x; int y; bit last;} px_t;
  typedef struct {int x0; int y0; int x1; int y1; int col; int npix; int rnd; int abort_after;} vec_t;

  px_t  sb[$];
  px_t  log_q[$];
  vec_t vt[10];

  bresenham_line_engine #(.COORD_W(CW), .COLOR_W(KW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .color(color), .abort(abort), .busy(busy), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .px_last(px_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference Bresenham walk pushing expected pixels into the scoreboard
  function automatic void model(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, e2, cx, cy;
    dx  = (bx > ax) ? bx - ax : ax - bx;
    dy  = (by > ay) ? ay - by : by - ay;
    sx  = (ax < bx) ? 1 : -1;
    sy  = (ay < by) ? 1 : -1;
    err = dx + dy;
    cx  = ax;
    cy  = ay;
    forever begin
      sb.push_back('{cx, cy, (cx == bx && cy == by)});
      if (cx == bx && cy == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endfunction

  task automatic run_line(input vec_t v);
    int cyc = 0, acc = 0, hx = 0, hy = 0, hl = 0, hc = 0;
    bit seen = 0, held = 0, fin = 0, ab = 0, dn = 0;
    px_t e;
    sb.delete();
    log_q.delete();
    model(v.x0, v.y0, v.x1, v.y1);
    @(negedge clk);
    x0 = CW'(v.x0); y0 = CW'(v.y0); x1 = CW'(v.x1); y1 = CW'(v.y1);
    color = KW'(v.col);
    start = 1;
    while (!fin && !ab && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 0;
        chk("setup_valid", int'(px_valid), 0);
        chk("setup_busy", int'(busy), 1);
      end
      if (px_valid) begin
        if (!seen) begin
          seen = 1;
          chk("latency", cyc, 2);
        end
        if (held) begin
          chk("hold_x", int'(px_x), hx);
          chk("hold_y", int'(px_y), hy);
          chk("hold_last", int'(px_last), hl);
          chk("hold_color", int'(px_color), hc);
        end
        if (v.rnd != 0) begin
          px_ready = ($urandom_range(0, 2) != 0);
          start = ($urandom_range(0, 3) == 0);
          x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
          color = KW'($urandom);
        end else px_ready = 1;
        if (px_ready) begin
          if (sb.size() == 0) chk("extra_pixel", 1, 0);
          else begin
            e = sb.pop_front();
            chk("px_x", int'(px_x), e.x);
            chk("px_y", int'(px_y), e.y);
            chk("px_last", int'(px_last), int'(e.last));
            chk("px_color", int'(px_color), v.col);
          end
          log_q.push_back('{int'(px_x), int'(px_y), px_last});
          acc++;
          held = 0;
          if (px_last) begin fin = 1; start = 0; end
          if (acc == v.abort_after) begin ab = 1; start = 0; end
        end else begin
          held = 1;
          hx = int'(px_x); hy = int'(px_y); hl = int'(px_last); hc = int'(px_color);
        end
      end
    end
    if (!fin && !ab) chk("timeout", cyc, -1);
    if (fin) begin
      @(negedge clk);
      px_ready = 0;
      chk("done_pulse", int'(done), 1);
      chk("done_valid", int'(px_valid), 0);
      chk("done_busy", int'(busy), 1);
      @(negedge clk);
      chk("done_clear", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
      chk("pixel_count", acc, v.npix);
      chk("sb_empty", sb.size(), 0);
    end
    if (ab) begin
      @(negedge clk);
      abort = 1;
      px_ready = 0;
      @(negedge clk);
      abort = 0;
      chk("abort_valid", int'(px_valid), 0);
      chk("abort_busy", int'(busy), 0);
      dn = done;
      repeat (3) begin
        @(negedge clk);
        dn = dn | done;
      end
      chk("abort_no_done", int'(dn), 0);
    end
    px_ready = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(px_valid), 0);
    chk({tag, "_x"}, int'(px_x), 0);
    chk({tag, "_y"}, int'(px_y), 0);
    chk({tag, "_color"}, int'(px_color), 0);
    chk({tag, "_last"}, int'(px_last), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int steep_x[5] = '{3, 2, 1, 1, 0};
    int steep_y[5] = '{3, 4, 5, 6, 7};
    vt[0] = '{0, 9, 8, 9, 'hA5, 9, 0, -1};
    vt[1] = '{3, 3, 0, 7, 'h3C, 5, 0, -1};
    vt[2] = '{5, 5, 5, 5, 'h81, 1, 0, -1};
    vt[3] = '{0, 0, 255, 255, 'h11, 256, 0, -1};
    vt[4] = '{255, 255, 0, 0, 'hEE, 256, 0, -1};
    vt[5] = '{0, 0, 10, 3, 'h5A, 11, 1, -1};
    vt[6] = '{7, 2, 1, 0, 'h77, 7, 1, -1};
    vt[7] = '{2, 8, 2, 1, 'hC3, 8, 0, -1};
    vt[8] = '{0, 0, 20, 5, 'h99, 0, 0, 3};
    vt[9] = '{1, 1, 4, 2, 'h42, 4, 0, -1};
    #1;
    chk_zero("reset");
    #20;
    @(negedge clk);
    n_rst = 1;
    for (int i = 0; i < 10; i++) begin
      run_line(vt[i]);
      if (i == 1) begin
        chk("steep_len", log_q.size(), 5);
        for (int k = 0; k < 5 && k < log_q.size(); k++) begin
          chk("steep_x", log_q[k].x, steep_x[k]);
          chk("steep_y", log_q[k].y, steep_y[k]);
        end
      end
    end
    @(negedge clk);
    x0 = 0; y0 = 0; x1 = 50; y1 = 50; color = 8'h3F;
    start = 1;
    @(negedge clk);
    start = 0;
    px_ready = 1;
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", int'(px_valid), 1);
    #2 n_rst = 0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    px_ready = 0;
    n_rst = 1;
    @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    run_line(vt[0]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bresenham_line_engine.md
Name: bresenham_line_engine

Overview:
Parametrised all-octant Bresenham line rasteriser for the 2D GPU drawing pipeline. It accepts a line command with two endpoints and a colour, then streams one pixel per cycle through a valid/ready interface to the frame-buffer writer. It supports any slope and direction, configurable coordinate and colour widths, output backpressure, abort, and a last-pixel marker.

Parameters:
COORD_W, 8, width of each unsigned coordinate (x0, y0, x1, y1, px_x, px_y)
COLOR_W, 8, width of the pixel colour/attribute carried with each pixel

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
x0  input  COORD_W  start x
y0  input  COORD_W  start y
x1  input  COORD_W  end x
y1  input  COORD_W  end y
color  input  COLOR_W  line colour, latched with start
abort  input  1  synchronous cancel of the current line
busy  output  1  high in SETUP, DRAW and DONE
px_valid  output  1  pixel on px_x/px_y is valid
px_ready  input  1  downstream accepts the pixel
px_x  output  COORD_W  pixel x
px_y  output  COORD_W  pixel y
px_color  output  COLOR_W  latched colour
px_last  output  1  current pixel is the endpoint (x1, y1)
done  output  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset is one clock and asynchronous active-low. While n_rst=0, all outputs are 0, the FSM is in IDLE, and all internal registers are 0.
- FSM states: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - start=1 latches x0, y0, x1, y1 and color, then moves to SETUP.
  - start is ignored in every other state; no queueing.
- SETUP (1 cycle) computes:
  - dx = |x1-x0|
  - dy = -|y1-y0|
  - sx = +1 if x0<x1, else -1
  - sy = +1 if y0<y1, else -1
  - err = dx+dy
  - x = x0, y = y0
  - Then moves to DRAW.
- Arithmetic widths:
  - err is signed COORD_W+2 bits; e2 = 2*err is signed COORD_W+3 bits.
  - No overflow is permitted for any endpoint pair in [0, 2^COORD_W - 1].
- DRAW:
  - px_valid=1; px_x=x; px_y=y; px_last=(x==x1 && y==y1).
  - On px_valid && px_ready with px_last=0, apply one step using the old err for both tests:
    - if e2 >= dy: err += dy, x += sx
    - if e2 <= dx: err += dx, y += sy
  - On px_valid && px_ready with px_last=1, go to DONE with px_valid=0 next cycle.
- Backpressure: while px_ready=0 in DRAW, px_x, px_y, px_color and px_last hold stable and px_valid stays 1.
- Latency and throughput:
  - start high in cycle N gives the first px_valid in cycle N+2.
  - With px_ready held at 1, one pixel is accepted per cycle.
  - Total pixels per line = max(dx, |dy|) + 1.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. start is accepted again from the following cycle.
- abort=1 in SETUP or DRAW:
  - Next state is IDLE; px_valid drops next cycle; done is not pulsed.
  - A pixel handshaking in the same cycle as abort counts as delivered.
  - abort is ignored in IDLE and DONE.
- Degenerate line (x0==x1 && y0==y1): exactly one pixel, with px_last=1.
- Coordinates never wrap: stepping stops at the endpoint, so x and y stay within [min, max] of the endpoints.
- px_color equals the latched color for every pixel of the line. Input changes after start have no effect until the next command.
- Reset mid-line: immediate return to IDLE with outputs at 0; no done pulse.

Test Plan:
- Horizontal line, px_ready=1, (0,9)->(8,9): 9 pixels x=0..8, y=9; px_last only on (8,9); done pulses one cycle later; first px_valid 2 cycles after start.
- Steep negative octant, (3,3)->(0,7): exact sequence (3,3), (2,4), (1,5), (1,6), (0,7); px_last on (0,7).
- Single point, (5,5)->(5,5): one pixel (5,5) with px_last=1, then done.
- Full-range diagonal, (0,0)->(255,255) with COORD_W=8: 256 pixels (i,i); no wrap or overflow. Repeat reversed (255,255)->(0,0).
- Backpressure: random px_ready toggling on (0,0)->(10,3); outputs stable while px_ready=0; same 11-pixel sequence as with px_ready=1; start pulses during DRAW are ignored.
- Abort and reset:
  - abort asserted after the 3rd accepted pixel: px_valid=0 next cycle, no done, busy=0; a new command then runs correctly.
  - n_rst asserted mid-line: all outputs 0 immediately.
